// File: rtl/debounce_pkg.sv
// Shared types and default timing for the push-button debounce bank.
// Defaults assume a 50 MHz clk: 20 ms stability window, 2 s long press.
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_t;

  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_STABLE_CYCLES = 1_000_000;
  localparam int DEFAULT_LONG_CYCLES   = 100_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: synchroniser, stability-qualified FSM, press/release strobes.
// Long-press strobe is built only when DEBOUNCE_BANK_LONG_PRESS_EN is defined.
//
// state        | meaning
// RELEASED     | pb_level=0, waiting for a sample of 1
// PRESS_WAIT   | counting consecutive samples of 1
// PRESSED      | pb_level=1, waiting for a sample of 0
// RELEASE_WAIT | pb_level=1, counting consecutive samples of 0
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_in,
  output logic pb_level,
  output logic pb_press,
  output logic pb_release,
  output logic pb_long
);

  localparam int               CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  if (SYNC_STAGES < 2 || STABLE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
    $error("debounce_channel: illegal parameter value");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sample;
  db_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_d, release_d;
  logic                   press_q, release_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pb_in};
  end

  assign sample = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (sample) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!sample) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!sample) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to 1 resumes the press silently.
        if (sample) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = RELEASED;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign pb_level   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
  assign pb_press   = press_q;
  assign pb_release = release_q;

`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
  localparam int                LONG_W   = $clog2(LONG_CYCLES + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] long_q, long_d;
  logic              long_hit, long_pulse_q;

  // Stop counting on the release edge so pb_long never coincides with pb_release.
  always_comb begin
    long_d   = long_q;
    long_hit = 1'b0;
    if (state_d == RELEASED) begin
      long_d = '0;
    end else if ((state_q == PRESSED || state_q == RELEASE_WAIT) && long_q != LONG_MAX) begin
      long_d   = long_q + 1'b1;
      long_hit = (long_q + 1'b1 == LONG_MAX);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      long_q       <= '0;
      long_pulse_q <= 1'b0;
    end else begin
      long_q       <= long_d;
      long_pulse_q <= long_hit;
    end
  end

  assign pb_long = long_pulse_q;
`else
  assign pb_long = 1'b0;
`endif

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced push-button channels on a single clock.
// Optional long-press strobe: define DEBOUNCE_BANK_LONG_PRESS_EN.
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int LONG_CYCLES   = DEFAULT_LONG_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] pb_in,
  output logic [CHANNELS-1:0] pb_level,
  output logic [CHANNELS-1:0] pb_press,
  output logic [CHANNELS-1:0] pb_release,
  output logic [CHANNELS-1:0] pb_long
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .pb_in     (pb_in[i]),
      .pb_level  (pb_level[i]),
      .pb_press  (pb_press[i]),
      .pb_release(pb_release[i]),
      .pb_long   (pb_long[i])
    );
  end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: 2 channels, STABLE_CYCLES=8, LONG_CYCLES=32.
module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] pb_in = 2'b00;
  logic [1:0] pb_level, pb_press, pb_release, pb_long;

  int n_cmp = 0;
  int n_err = 0;
  int edge_n = 0;

  always #5 clk = ~clk;

  debounce_bank #(
    .CHANNELS     (2),
    .SYNC_STAGES  (2),
    .STABLE_CYCLES(8),
    .LONG_CYCLES  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pb_in     (pb_in),
    .pb_level  (pb_level),
    .pb_press  (pb_press),
    .pb_release(pb_release),
    .pb_long   (pb_long)
  );

  typedef struct {
    logic [1:0] in;
    int         reps;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] rel;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %b expected %b", name, edge_n, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " level"}, pb_level, 2'b00);
    check({tag, " press"}, pb_press, 2'b00);
    check({tag, " release"}, pb_release, 2'b00);
    check({tag, " long"}, pb_long, 2'b00);
  endtask

  // Leaves rst low just after an edge; the next edge is numbered 0.
  task automatic do_reset();
    rst   = 1'b1;
    pb_in = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst    = 1'b0;
    edge_n = -1;
  endtask

  initial begin
    int press_cnt, rel_cnt, long_cnt, both_cnt, press_edge, long_edge;

    // Clean press/release on ch0, simultaneous press, glitch in RELEASE_WAIT, double release.
    vecs[0]  = '{2'b01, 10, 2'b00, 2'b00, 2'b00};
    vecs[1]  = '{2'b01,  1, 2'b01, 2'b01, 2'b00};
    vecs[2]  = '{2'b01,  9, 2'b01, 2'b00, 2'b00};
    vecs[3]  = '{2'b00, 10, 2'b01, 2'b00, 2'b00};
    vecs[4]  = '{2'b00,  1, 2'b00, 2'b00, 2'b01};
    vecs[5]  = '{2'b00,  4, 2'b00, 2'b00, 2'b00};
    vecs[6]  = '{2'b11, 10, 2'b00, 2'b00, 2'b00};
    vecs[7]  = '{2'b11,  1, 2'b11, 2'b11, 2'b00};
    vecs[8]  = '{2'b11,  5, 2'b11, 2'b00, 2'b00};
    vecs[9]  = '{2'b00,  4, 2'b11, 2'b00, 2'b00};
    vecs[10] = '{2'b11,  8, 2'b11, 2'b00, 2'b00};
    vecs[11] = '{2'b00, 10, 2'b11, 2'b00, 2'b00};
    vecs[12] = '{2'b00,  1, 2'b00, 2'b00, 2'b11};
    vecs[13] = '{2'b00,  3, 2'b00, 2'b00, 2'b00};

    do_reset();
    for (int v = 0; v < 14; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        pb_in = vecs[v].in;
        tick();
        check($sformatf("vec%0d level", v), pb_level, vecs[v].level);
        check($sformatf("vec%0d press", v), pb_press, vecs[v].press);
        check($sformatf("vec%0d release", v), pb_release, vecs[v].rel);
        check($sformatf("vec%0d long", v), pb_long, 2'b00);
      end
    end

    // Bounce: ch0 toggles every 3 cycles for 30 cycles, final rise at edge 30.
    do_reset();
    press_cnt = 0; rel_cnt = 0; press_edge = -1;
    for (int e = 0; e < 60; e++) begin
      pb_in = (e >= 30) ? 2'b01 : {1'b0, ((e / 3) % 2) == 0};
      tick();
      if (pb_press != 2'b00) begin
        press_cnt++;
        if (press_edge < 0) press_edge = edge_n;
      end
      if (pb_release != 2'b00) rel_cnt++;
    end
    check_int("bounce press count", press_cnt, 1);
    check_int("bounce press edge", press_edge, 40);
    check_int("bounce release count", rel_cnt, 0);
    check("bounce final level", pb_level, 2'b01);

    // Long hold on ch0.
    do_reset();
    press_cnt = 0; long_cnt = 0; both_cnt = 0; press_edge = -1; long_edge = -1;
    pb_in = 2'b01;
    for (int e = 0; e < 120; e++) begin
      tick();
      if (pb_press == 2'b01) begin
        press_cnt++;
        press_edge = edge_n;
      end
      if (pb_long != 2'b00) begin
        long_cnt++;
        if (long_edge < 0) long_edge = edge_n;
      end
      if ((pb_press & pb_long) != 2'b00 || (pb_release & pb_long) != 2'b00) both_cnt++;
    end
    check_int("hold press count", press_cnt, 1);
    check_int("hold press edge", press_edge, 10);
    check_int("hold strobe overlap", both_cnt, 0);
`ifdef DEBOUNCE_BANK_LONG_PRESS_EN
    check_int("long count", long_cnt, 1);
    check_int("long edge", long_edge, 42);
`else
    check_int("long count (disabled)", long_cnt, 0);
`endif

    // Release after long hold clears the long counter; a new hold fires afresh.
    pb_in = 2'b00;
    repeat (12) tick();
    check("post-hold level", pb_level, 2'b00);

    // Reset mid-press: assert after edge 12, deassert before edge 15.
    do_reset();
    pb_in = 2'b01;
    repeat (13) tick();
    check("pre-reset level", pb_level, 2'b01);
    rst = 1'b1;
    #1;
    check_zero_outputs("async reset");
    tick();
    tick();
    check_zero_outputs("held reset");
    rst = 1'b0;
    for (int e = 15; e <= 26; e++) begin
      tick();
      check($sformatf("requal press e%0d", e), pb_press, (e == 25) ? 2'b01 : 2'b00);
      check($sformatf("requal level e%0d", e), pb_level, (e >= 25) ? 2'b01 : 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised, multi-channel push-button conditioner; successor to the single-button debouncer. Each channel synchronises a raw pad input, qualifies it with a per-channel stability counter instead of a slow-clock tick, and emits a clean level plus one-cycle press and release strobes. An optional long-press strobe is also available. It sits between the board buttons and the game/control FSMs, all on the single system clock.

## Interface
- `CHANNELS`, 4: number of independent button channels (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `STABLE_CYCLES`, 1_000_000: consecutive identical synchronised samples required to accept a change (20 ms at 50 MHz; ≥1).
- `LONG_CYCLES`, 100_000_000: cycles a qualified press must be held before `pb_long` fires (2 s at 50 MHz; ≥1).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `pb_in` in CHANNELS: raw asynchronous button inputs, active-high.
- `pb_level` out CHANNELS: debounced level.
- `pb_press` out CHANNELS: one-cycle pulse when `pb_level` rises.
- `pb_release` out CHANNELS: one-cycle pulse when `pb_level` falls.
- `pb_long` out CHANNELS: one-cycle pulse on long press; constant 0 when the feature is compiled out.

## Operation
- Channels are fully independent. There is no shared state except `clk` and `rst`.
- Per-channel FSM:
  - RELEASED: `pb_level`=0.
  - PRESS_WAIT: counting samples of 1.
  - PRESSED: `pb_level`=1.
  - RELEASE_WAIT: counting samples of 0.
- RELEASED → PRESS_WAIT when the synchronised sample is 1; the counter is loaded with 1.
- PRESS_WAIT:
  - A sample of 0 returns the FSM to RELEASED and clears the counter.
  - When the counter equals STABLE_CYCLES and the sample is 1, go to PRESSED, set `pb_level`=1 and pulse `pb_press`.
- PRESSED ↔ RELEASE_WAIT mirror the rules above; `pb_release` fires on entry to RELEASED.
- Stability counter width is `$clog2(STABLE_CYCLES+1)`. It never exceeds STABLE_CYCLES.
- Glitches shorter than STABLE_CYCLES samples produce no output activity.
- While in RELEASE_WAIT, `pb_level` stays 1 and the long-press counter keeps counting. The counter is cleared only on entry to RELEASED.

## Timing
- Reset: all outputs are 0, all FSMs are in RELEASED, and the synchroniser and counter flops are 0. Reset takes effect immediately on `rst` assertion.
- Latency: a clean raw edge first sampled at clk edge 0 appears on `pb_level` and the strobe at edge SYNC_STAGES+STABLE_CYCLES.
- `pb_press`, `pb_release` and `pb_long` are registered, high for exactly one cycle, and never high simultaneously on the same channel.
- Reset mid-qualification or mid-press discards all progress. A button still held after `rst` deasserts is re-qualified as a new press, with a full window and a new `pb_press`.
- Simultaneous presses on several channels produce strobes in the same cycle.
- A new edge accepted during RELEASE_WAIT restarts nothing: the FSM returns to PRESSED with no strobe.

## Configuration
- Macro: `DEBOUNCE_BANK_LONG_PRESS_EN`.
- Defined:
  - Each channel has a saturating counter of width `$clog2(LONG_CYCLES+1)`, counting in PRESSED/RELEASE_WAIT.
  - `pb_long` pulses once when the count reaches LONG_CYCLES after the `pb_press` cycle.
  - It does not re-fire until the channel returns to RELEASED.
- Undefined: no long counter is built and `pb_long` is tied to 0. The port list is unchanged.

## Structure
- Package `debounce_pkg`:
  - FSM state typedef `db_state_t` (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT).
  - Default timing constants (50 MHz cycle counts for 20 ms and 2 s).
- Sub-module `debounce_channel`: one synchroniser, FSM, stability counter and optional long counter. `debounce_bank` instantiates it CHANNELS times in a generate loop.

## Test plan
Bench parameters: CHANNELS=2, SYNC_STAGES=2, STABLE_CYCLES=8, LONG_CYCLES=32.
- Clean press: ch0 held high from cycle 0 → `pb_level[0]` and a 1-cycle `pb_press[0]` at cycle 10. Ch1 stays silent.
- Bounce: ch0 toggles every 3 cycles for 30 cycles, then holds 1 → single `pb_press[0]` exactly 10 cycles after the final toggle. No `pb_release` pulses.
- Release: after a qualified press, drop ch0 at cycle T → `pb_level[0]`=0 and `pb_release[0]` at T+10.
- Long press (macro on): hold ch0 → `pb_press` at 10, then `pb_long` once at 42. It does not repeat while held. With the macro off, `pb_long` is always 0.
- Reset mid-press: assert `rst` at cycle 12 while ch0 is held → outputs 0 immediately. Deassert at cycle 15 → new `pb_press[0]` at cycle 25.
- Both channels are pressed at the same cycle → `pb_press`=2'b11 in one cycle.
